alu_arbiter: RTL and testbench

//  Shares one 4-bit ALU (add/mult/mod/AND; op 0..3, 8-bit result) between two requesters.

---
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one 4-bit ALU between two requesters.
// One operation in flight at a time: accept (IDLE), compute (EXEC), hold result (RESP).

module alu_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [7:0] result
);

  // Combinational ALU; mod by zero yields 0 here so the output never goes X.
  always_comb begin
    result = 8'h00;
    case (op)
      2'd0: result = {4'h0, a} + {4'h0, b};
      2'd1: result = {4'h0, a} * {4'h0, b};
      2'd2: begin
        if (b != 4'h0) begin
          result = {4'h0, a % b};
        end else begin
          result = 8'h00;
        end
      end
      2'd3: result = {4'h0, a & b};
      default: result = 8'h00;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int          CNT_W    = 8,
  parameter logic [7:0]  DIV0_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_id,
  output logic             rsp_div0,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_result_q, rsp_result_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_div0_q, rsp_div0_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;
  logic              grant_s;
  logic              div0_s;
  logic [7:0]        alu_result_s;

  alu_core u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result_s)
  );

  assign div0_s = (op_q == 2'd2) && (b_q == 4'h0);

  // Grant selection: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_s;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_s;

  // Next-state and datapath for the accept / compute / respond sequence.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_div0_d   = rsp_div0_q;
    busy_d       = busy_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d          = grant_s ? req1_a  : req0_a;
          b_d          = grant_s ? req1_b  : req0_b;
          op_d         = grant_s ? req1_op : req0_op;
          id_d         = grant_s;
          last_grant_d = grant_s;
          state_d      = EXEC;
          busy_d       = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      EXEC: begin
        rsp_result_d = div0_s ? DIV0_VAL : alu_result_s;
        rsp_div0_d   = div0_s;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
        busy_d       = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = IDLE;
          busy_d      = 1'b0;
        end else begin
          state_d = RESP;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= 4'h0;
      b_q          <= 4'h0;
      op_q         <= 2'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_id_q     <= 1'b0;
      rsp_div0_q   <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_div0_q   <= rsp_div0_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_div0   = rsp_div0_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner sequences, and random traffic
// checked every cycle against a transaction-level reference model.

module tb_alu_arbiter;

  localparam logic [7:0] DIV0_VAL = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_div0, busy;
  logic [7:0] rsp_result, op_count;
  logic       req0_ready_w, req1_ready_w, rsp_valid_w, rsp_id_w, rsp_div0_w, busy_w;
  logic [7:0] rsp_result_w;
  logic [1:0] op_count_w;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(8), .DIV0_VAL(DIV0_VAL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
    .rsp_div0(rsp_div0), .busy(busy), .op_count(op_count)
  );

  // Second instance with a 2-bit counter shares the stimulus to exercise wrap-around.
  alu_arbiter #(.CNT_W(2), .DIV0_VAL(DIV0_VAL)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_w), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready_w), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_result(rsp_result_w), .rsp_id(rsp_id_w),
    .rsp_div0(rsp_div0_w), .busy(busy_w), .op_count(op_count_w)
  );

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic       div0;
    logic [1:0] cnt_w;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [8:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      2'd0:    return {1'b0, 8'(ia + ib)};
      2'd1:    return {1'b0, 8'(ia * ib)};
      2'd2:    return (ib == 0) ? {1'b1, DIV0_VAL} : {1'b0, 8'(ia % ib)};
      default: return {1'b0, 8'(ia & ib)};
    endcase
  endfunction

  // Transaction model: one op in flight, result due two cycles after acceptance.
  task automatic monitor();
    logic       pend = 1'b0;
    logic       last = 1'b1;
    int         age  = 0;
    int         cnt  = 0;
    logic [8:0] r;
    logic [7:0] e_res = 8'h00;
    logic       e_id = 1'b0, e_div0 = 1'b0, x0, x1, erv;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; last = 1'b1; age = 0; cnt = 0;
      end else begin
        x0  = !pend && req0_valid && (!req1_valid || last);
        x1  = !pend && req1_valid && (!req0_valid || !last);
        erv = pend && (age >= 2);
        chk("ready_excl", int'(req0_ready && req1_ready), 0);
        chk("req0_ready", int'(req0_ready), int'(x0));
        chk("req1_ready", int'(req1_ready), int'(x1));
        chk("busy", int'(busy), int'(pend));
        chk("rsp_valid", int'(rsp_valid), int'(erv));
        chk("w_rsp_valid", int'(rsp_valid_w), int'(erv));
        if (erv) begin
          chk("rsp_result", int'(rsp_result), int'(e_res));
          chk("rsp_id", int'(rsp_id), int'(e_id));
          chk("rsp_div0", int'(rsp_div0), int'(e_div0));
        end
        chk("op_count", int'(op_count), cnt % 256);
        chk("op_count_w", int'(op_count_w), cnt % 4);
        if (pend) begin
          if (erv && rsp_ready) begin
            pend = 1'b0;
            cnt++;
          end else begin
            age++;
          end
        end else if (x0 || x1) begin
          r      = x1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
          e_res  = r[7:0];
          e_div0 = r[8];
          e_id   = x1;
          last   = x1;
          pend   = 1'b1;
          age    = 1;
        end
      end
    end
  endtask

  task automatic wait_ready(input logic id, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
    end
  endtask

  task automatic drain();
    logic got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk("drain_rsp", int'(got), 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    @(posedge clk); #1;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end
    wait_ready(v.id, ok);
    chk("accept", int'(ok), 1);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_resp_valid", int'(rsp_valid), 1);
    chk("vec_result", int'(rsp_result), int'(v.res));
    chk("vec_id", int'(rsp_id), int'(v.id));
    chk("vec_div0", int'(rsp_div0), int'(v.div0));
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_cnt_w", int'(op_count_w), int'(v.cnt_w));
  endtask

  task automatic reset_pulse(input string name);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk({name, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({name, "_rsp_result"}, int'(rsp_result), 0);
    chk({name, "_rsp_id"}, int'(rsp_id), 0);
    chk({name, "_rsp_div0"}, int'(rsp_div0), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_op_count"}, int'(op_count), 0);
    chk({name, "_op_count_w"}, int'(op_count_w), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    logic ok, h0, h1;
    int   k;
    int   got_id[4];
    int   got_res[4];
    int   exp_id[4]  = '{0, 1, 0, 1};
    int   exp_res[4] = '{8, 1, 8, 1};
    logic [7:0] cnt_before;

    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req0_op = 2'd0;
    req1_a = 4'h0; req1_b = 4'h0; req1_op = 2'd0;
    vecs[0] = '{1'b0, 4'd5,  4'd3,  2'd1, 8'd15,  1'b0, 2'd1};
    vecs[1] = '{1'b1, 4'd9,  4'd0,  2'd2, 8'd0,   1'b1, 2'd2};
    vecs[2] = '{1'b1, 4'd9,  4'd4,  2'd2, 8'd1,   1'b0, 2'd3};
    vecs[3] = '{1'b0, 4'd15, 4'd15, 2'd1, 8'd225, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 4'd15, 4'd15, 2'd0, 8'd30,  1'b0, 2'd1};
    vecs[5] = '{1'b0, 4'd12, 4'd10, 2'd3, 8'd8,   1'b0, 2'd2};
    vecs[6] = '{1'b1, 4'd7,  4'd3,  2'd2, 8'd1,   1'b0, 2'd3};
    vecs[7] = '{1'b0, 4'd0,  4'd0,  2'd2, 8'd0,   1'b1, 2'd0};
    vecs[8] = '{1'b1, 4'd15, 4'd1,  2'd2, 8'd0,   1'b0, 2'd1};
    vecs[9] = '{1'b0, 4'd13, 4'd5,  2'd2, 8'd3,   1'b0, 2'd2};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_busy", int'(busy), 0);
    chk("init_rsp_valid", int'(rsp_valid), 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Ties: both requesters stay valid, grants must alternate starting with 0.
    reset_pulse("rst_idle");
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_op = 2'd0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_op = 2'd3;
    rsp_ready  = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        got_id[k]  = int'(rsp_id);
        got_res[k] = int'(rsp_result);
        k++;
      end
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    chk("rr_count", k, 4);
    for (int i = 0; i < k; i++) begin
      chk("rr_id", got_id[i], exp_id[i]);
      chk("rr_result", got_res[i], exp_res[i]);
    end

    // Backpressure: response held for 10 cycles while requester 1 waits.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_op = 2'd0;
    wait_ready(1'b0, ok);
    chk("bp_accept", int'(ok), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_op = 2'd1;
    ok = 1'b0;
    for (int c = 0; c < 6 && !ok; c++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("bp_rsp_seen", int'(ok), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_result", int'(rsp_result), 5);
      chk("bp_hold_id", int'(rsp_id), 0);
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
    end
    cnt_before = op_count;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_count_step", int'(op_count), int'(cnt_before + 8'd1));
    if (!req1_ready) wait_ready(1'b1, ok);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain();

    // Reset in EXEC and in RESP discards the operation.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7; req0_op = 2'd1;
    wait_ready(1'b0, ok);
    @(posedge clk); #1 req0_valid = 1'b0;
    reset_pulse("rst_exec");
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd2; req1_op = 2'd0;
    wait_ready(1'b1, ok);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_resp_valid", int'(rsp_valid), 1);
    reset_pulse("rst_resp");
    repeat (4) @(negedge clk);
    chk("post_rst_no_rsp", int'(rsp_valid), 0);

    // Random traffic; requesters hold valid and data until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0) req0_valid = 1'b0;
      if (h1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1;
        req0_a  = 4'($urandom);
        req0_b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        req0_op = 2'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1;
        req1_a  = 4'($urandom);
        req1_b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        req1_op = 2'($urandom);
      end
      rsp_ready = 1'($urandom);
    end
    @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("end_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
